// File: rtl/sp_chip_emu.sv
// rtl/sp_chip_emu.sv - chip-side emulator of the SuperMario readout/SPI port
//
// Stands in for the silicon on the readout master's SPI/stream port. It receives
// 8-bit SPI commands, sends back a status byte and streams frame bytes.
// The whole block runs on the chip clock (clk == SP_CLK). Every output is registered.
//
// Ports
//   clk          chip clock (SP_CLK)
//   nrst         asynchronous active-low reset
//   SP_NRST      chip reset, synchronous active-low, same effect as nrst
//   SP_DIN       unused chip data input
//   SP_SPI_CS    SPI chip select, active low
//   SP_SPI_MOSI  SPI data in, MSB first, one bit per clk while CS is low
//   SP_SPI_MISO  SPI data out, status byte MSB first, 0 while CS is high
//   SP_DOUT      stream byte, valid while SP_UPDATE is high
//   SP_UPDATE    byte strobe; held high by the reset-release quirk until the first CYCLE
//   SP_EOF       high together with SP_UPDATE on the last byte of a frame
//   cmd_valid    one-cycle pulse for each accepted command
//   cmd          last accepted command

module sp_chip_emu #(
  parameter int FRAME_BYTES = 4096,
  parameter int GAP         = 3,
  parameter bit UPDATE_BUG  = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       SP_NRST,
  input  logic [7:0] SP_DIN,
  input  logic       SP_SPI_CS,
  input  logic       SP_SPI_MOSI,
  output logic       SP_SPI_MISO,
  output logic [7:0] SP_DOUT,
  output logic       SP_UPDATE,
  output logic       SP_EOF,
  output logic       cmd_valid,
  output logic [7:0] cmd
);

  localparam int BW = $clog2(FRAME_BYTES);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);
  localparam logic [7:0]    OP_IDLE   = 8'hE0;
  localparam logic [7:0]    OP_CYCLE  = 8'h00;

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_IDLE   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            quirk_q, quirk_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]      data_q, data_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]      rx_q, rx_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      miso_sh_q, miso_sh_d;
  logic            cs_prev_q, cs_prev_d;
  logic [7:0]      cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      dout_q, dout_d;
  logic            update_q, update_d;
  logic            eof_q, eof_d;
  logic            miso_q, miso_d;

  logic [7:0]      status;
  logic            unused_din;

  assign unused_din = ^SP_DIN;

  // Status is sampled when CS falls and then shifted out MSB first.
  assign status = {state_q == S_STREAM, quirk_q, frame_cnt_q[5:0]};

  always_comb begin
    state_d     = state_q;
    quirk_d     = quirk_q;
    byte_cnt_d  = byte_cnt_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = data_q;
    gap_cnt_d   = gap_cnt_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    miso_sh_d   = miso_sh_q;
    cs_prev_d   = SP_SPI_CS;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    dout_d      = 8'd0;
    update_d    = 1'b0;
    eof_d       = 1'b0;
    miso_d      = 1'b0;

    // SPI receive and status transmit
    if (!SP_SPI_CS) begin
      rx_d = {rx_q[6:0], SP_SPI_MOSI};
      if (cs_prev_q) begin
        // CS has just fallen. This cycle already carries the first bit in each direction.
        bit_cnt_d = 4'd1;
        miso_d    = status[7];
        miso_sh_d = {status[6:0], 1'b0};
      end else begin
        bit_cnt_d = (bit_cnt_q == 4'd8) ? 4'd8 : bit_cnt_q + 4'd1;
        miso_d    = miso_sh_q[7];
        miso_sh_d = {miso_sh_q[6:0], 1'b0};
      end
    end else if (!cs_prev_q && bit_cnt_q == 4'd8) begin
      cmd_d       = rx_q;
      cmd_valid_d = 1'b1;
    end

    // Stream FSM. A command acts in the cycle after its cmd_valid pulse.
    case (state_q)
      S_RST: begin
        state_d = S_IDLE;
        quirk_d = UPDATE_BUG;
      end
      S_IDLE: begin
        if (cmd_valid_q && cmd_q == OP_CYCLE) begin
          state_d    = S_STREAM;
          byte_cnt_d = '0;
          data_d     = 8'd0;
          gap_cnt_d  = '0;
        end
      end
      S_STREAM: begin
        if (gap_cnt_q == '0) begin
          update_d  = 1'b1;
          dout_d    = data_q;
          eof_d     = (byte_cnt_q == LAST_BYTE);
          data_d    = data_q + 8'd1;
          gap_cnt_d = GAP_LOAD;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d  = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
        // A pulse issued on the decode edge still goes out. The counters restart and the partial frame is dropped.
        if (cmd_valid_q && cmd_q == OP_IDLE) begin
          state_d    = S_IDLE;
          byte_cnt_d = '0;
          data_d     = 8'd0;
          gap_cnt_d  = '0;
        end
      end
      default: state_d = S_RST;
    endcase

    if (cmd_valid_q && cmd_q == OP_CYCLE) begin
      quirk_d = 1'b0;
    end

    // Silicon quirk: while it is armed the strobe is held high with zero data.
    // Driving from quirk_d makes UPDATE fall in the cycle before the first real pulse.
    if (quirk_d) begin
      update_d = 1'b1;
      dout_d   = 8'd0;
      eof_d    = 1'b0;
    end

    if (!SP_NRST) begin
      state_d     = S_RST;
      quirk_d     = 1'b0;
      byte_cnt_d  = '0;
      frame_cnt_d = 16'd0;
      data_d      = 8'd0;
      gap_cnt_d   = '0;
      rx_d        = 8'd0;
      bit_cnt_d   = 4'd0;
      miso_sh_d   = 8'd0;
      cs_prev_d   = 1'b1;
      cmd_d       = 8'd0;
      cmd_valid_d = 1'b0;
      dout_d      = 8'd0;
      update_d    = 1'b0;
      eof_d       = 1'b0;
      miso_d      = 1'b0;
    end
  end

  // cs_prev resets high, so a CS already low when reset releases counts as a fresh falling edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_RST;
      quirk_q     <= 1'b0;
      byte_cnt_q  <= '0;
      frame_cnt_q <= 16'd0;
      data_q      <= 8'd0;
      gap_cnt_q   <= '0;
      rx_q        <= 8'd0;
      bit_cnt_q   <= 4'd0;
      miso_sh_q   <= 8'd0;
      cs_prev_q   <= 1'b1;
      cmd_q       <= 8'd0;
      cmd_valid_q <= 1'b0;
      dout_q      <= 8'd0;
      update_q    <= 1'b0;
      eof_q       <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      quirk_q     <= quirk_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      gap_cnt_q   <= gap_cnt_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_sh_q   <= miso_sh_d;
      cs_prev_q   <= cs_prev_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      dout_q      <= dout_d;
      update_q    <= update_d;
      eof_q       <= eof_d;
      miso_q      <= miso_d;
    end
  end

  assign SP_SPI_MISO = miso_q;
  assign SP_DOUT     = dout_q;
  assign SP_UPDATE   = update_q;
  assign SP_EOF      = eof_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;

endmodule
